// File: rtl/park_pkg.sv
// Shared definitions for the car-park exit gate: FSM state encoding,
// default sizing and a small helper for timer width calculation.
package park_pkg;

    localparam int CNT_W          = 4;
    localparam int DEF_CAPACITY   = 12;
    localparam int DEF_PAY_TICKS  = 16;
    localparam int DEF_GATE_TICKS = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PAY = 2'd1,
        ST_OPEN     = 2'd2
    } gate_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Saturating occupancy counter. A simultaneous inc/dec cancels out, so a car
// entering while another leaves at full is not flagged as an overflow.
module occupancy_counter
    import park_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, full_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != CAP) count_d = count_q + CNT_W'(1);
        end else if (dec && !inc) begin
            if (count_q != '0) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CAP);
        end
    end

    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign overflow = inc && !dec && full_q;

endmodule

// File: rtl/exit_gate_ctrl.sv
// Exit barrier controller: waits for payment while a car is at the exit,
// raises the gate on acceptance and decrements occupancy once the car clears.
module exit_gate_ctrl
    import park_pkg::*;
#(
    parameter int CAPACITY   = DEF_CAPACITY,
    parameter int PAY_TICKS  = DEF_PAY_TICKS,
    parameter int GATE_TICKS = DEF_GATE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_pulse,
    input  logic             exit_sense,
    input  logic             pay_valid,
    input  logic             pay_ok,
    input  logic             exit_clear,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty,
    output logic             full,
    output logic             pay_reject,
    output logic             timeout,
    output logic             alarm
);

    localparam int TMR_W = $clog2(max_int(PAY_TICKS, GATE_TICKS) + 1);
    localparam logic [TMR_W-1:0] PAY_LAST  = TMR_W'(PAY_TICKS - 1);
    localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_TICKS - 1);

    gate_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             sense_prev_q;
    logic             gate_open_q, gate_open_d;
    logic             pay_reject_q, pay_reject_d;
    logic             timeout_q, timeout_d;
    logic             alarm_q, alarm_d;
    logic             dec, overflow;

    occupancy_counter #(.CAPACITY(CAPACITY)) u_occ (
        .clk      (clk),
        .rst      (rst),
        .inc      (entry_pulse),
        .dec      (dec),
        .count    (occupancy),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + TMR_W'(1);
        dec          = 1'b0;
        pay_reject_d = 1'b0;
        timeout_d    = 1'b0;
        alarm_d      = overflow;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (exit_sense && !empty) begin
                    state_d = ST_WAIT_PAY;
                end else if (exit_sense && !sense_prev_q && empty) begin
                    alarm_d = 1'b1;
                end
            end
            ST_WAIT_PAY: begin
                // Accept beats reject beats timeout beats the car backing away.
                if (pay_valid && pay_ok) begin
                    state_d = ST_OPEN;
                    timer_d = '0;
                end else if (pay_valid) begin
                    pay_reject_d = 1'b1;
                    timer_d      = '0;
                end else if (timer_q == PAY_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                end else if (!exit_sense) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            end
            ST_OPEN: begin
                if (exit_clear) begin
                    dec     = 1'b1;
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (timer_q == GATE_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
        gate_open_d = (state_d == ST_OPEN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            sense_prev_q <= 1'b0;
            gate_open_q  <= 1'b0;
            pay_reject_q <= 1'b0;
            timeout_q    <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            sense_prev_q <= exit_sense;
            gate_open_q  <= gate_open_d;
            pay_reject_q <= pay_reject_d;
            timeout_q    <= timeout_d;
            alarm_q      <= alarm_d;
        end
    end

    assign gate_open  = gate_open_q;
    assign pay_reject = pay_reject_q;
    assign timeout    = timeout_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_exit_gate_ctrl.sv
// Bench for exit_gate_ctrl: directed scenarios plus random traffic, all
// compared each cycle against a cycle-level behavioural model of the car park.
module tb_exit_gate_ctrl;

    localparam int CAP   = 12;
    localparam int PAY_T = 16;
    localparam int GATE_T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_pulse = 1'b0;
    logic       exit_sense = 1'b0;
    logic       pay_valid = 1'b0;
    logic       pay_ok = 1'b0;
    logic       exit_clear = 1'b0;
    logic       gate_open;
    logic [3:0] occupancy;
    logic       empty, full, pay_reject, timeout, alarm;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: phase 0 = nobody at barrier, 1 = awaiting payment, 2 = barrier up
    int m_phase, m_elapsed, m_occ;
    bit m_prev_sense;
    int e_gate, e_occ, e_reject, e_timeout, e_alarm;

    exit_gate_ctrl #(.CAPACITY(CAP), .PAY_TICKS(PAY_T), .GATE_TICKS(GATE_T)) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_pulse (entry_pulse),
        .exit_sense  (exit_sense),
        .pay_valid   (pay_valid),
        .pay_ok      (pay_ok),
        .exit_clear  (exit_clear),
        .gate_open   (gate_open),
        .occupancy   (occupancy),
        .empty       (empty),
        .full        (full),
        .pay_reject  (pay_reject),
        .timeout     (timeout),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit s,
                              input bit pv, input bit pok, input bit clr);
        int  next_phase;
        bit  restart, leave;
        bit  alarm_now;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_occ = 0; m_prev_sense = 0;
            e_gate = 0; e_occ = 0; e_reject = 0; e_timeout = 0; e_alarm = 0;
            return;
        end
        next_phase = m_phase;
        restart = 0; leave = 0; alarm_now = 0;
        e_reject = 0; e_timeout = 0;
        if (m_phase == 0) begin
            if (s && m_occ > 0) next_phase = 1;
            else if (s && !m_prev_sense && m_occ == 0) alarm_now = 1;
        end else if (m_phase == 1) begin
            if (pv && pok) next_phase = 2;
            else if (pv) begin e_reject = 1; restart = 1; end
            else if (m_elapsed + 1 == PAY_T) begin e_timeout = 1; next_phase = 0; end
            else if (!s) next_phase = 0;
        end else begin
            if (clr) begin leave = 1; next_phase = 0; end
            else if (m_elapsed + 1 == GATE_T) begin e_timeout = 1; next_phase = 0; end
        end
        if (e && !leave) begin
            if (m_occ == CAP) alarm_now = 1;
            else m_occ = m_occ + 1;
        end else if (leave && !e && m_occ > 0) begin
            m_occ = m_occ - 1;
        end
        if (next_phase != m_phase || restart) m_elapsed = 0;
        else if (m_phase != 0) m_elapsed = m_elapsed + 1;
        m_phase      = next_phase;
        m_prev_sense = s;
        e_alarm = alarm_now;
        e_gate  = (m_phase == 2);
        e_occ   = m_occ;
    endtask

    task automatic cyc(input bit r, input bit e, input bit s,
                       input bit pv, input bit pok, input bit clr);
        rst = r; entry_pulse = e; exit_sense = s;
        pay_valid = pv; pay_ok = pok; exit_clear = clr;
        @(posedge clk);
        model_step(r, e, s, pv, pok, clr);
        #1;
        check_eq("gate_open",  int'(gate_open),  e_gate);
        check_eq("occupancy",  int'(occupancy),  e_occ);
        check_eq("empty",      int'(empty),      int'(e_occ == 0));
        check_eq("full",       int'(full),       int'(e_occ == CAP));
        check_eq("pay_reject", int'(pay_reject), e_reject);
        check_eq("timeout",    int'(timeout),    e_timeout);
        check_eq("alarm",      int'(alarm),      e_alarm);
    endtask

    task automatic do_reset();
        cyc(1, 1, 1, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic enter_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0, 0);
    endtask

    task automatic pay_and_open();
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0);
    endtask

    initial begin
        bit s_lvl;
        s_lvl = 0;

        do_reset();
        check_eq("rst_occ", int'(occupancy), 0);
        check_eq("rst_empty", int'(empty), 1);
        check_eq("rst_full", int'(full), 0);
        check_eq("rst_gate", int'(gate_open), 0);
        enter_n(3);
        check_eq("s1_occ3", int'(occupancy), 3);
        check_eq("s1_empty0", int'(empty), 0);
        pay_and_open();
        check_eq("s1_gate_up", int'(gate_open), 1);
        cyc(0, 0, 0, 0, 0, 1);
        check_eq("s1_gate_down", int'(gate_open), 0);
        check_eq("s1_occ2", int'(occupancy), 2);
        $display("scenario basic_exit done occ=%0d", occupancy);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            check_eq("s2_alarm", int'(alarm), (i == 12) ? 1 : 0);
        end
        check_eq("s2_occ12", int'(occupancy), 12);
        check_eq("s2_full", int'(full), 1);
        $display("scenario fill_to_capacity done occ=%0d", occupancy);

        do_reset();
        cyc(0, 0, 1, 0, 0, 0);
        check_eq("s3_alarm", int'(alarm), 1);
        check_eq("s3_gate", int'(gate_open), 0);
        cyc(0, 0, 1, 0, 0, 0);
        check_eq("s3_alarm_once", int'(alarm), 0);
        cyc(0, 0, 0, 0, 0, 0);
        $display("scenario exit_when_empty done alarm_seen");

        do_reset();
        enter_n(5);
        cyc(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < PAY_T; i++) begin
            cyc(0, 0, 1, 0, 0, 0);
            check_eq("s4_timeout", int'(timeout), (i == PAY_T - 1) ? 1 : 0);
        end
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        check_eq("s4_reject", int'(pay_reject), 1);
        check_eq("s4_occ5", int'(occupancy), 5);
        cyc(0, 0, 0, 0, 0, 0);
        $display("scenario pay_timeout_reject done occ=%0d", occupancy);

        do_reset();
        enter_n(12);
        pay_and_open();
        cyc(0, 1, 0, 0, 0, 1);
        check_eq("s5_occ12", int'(occupancy), 12);
        check_eq("s5_alarm0", int'(alarm), 0);
        $display("scenario swap_at_full done occ=%0d", occupancy);

        do_reset();
        enter_n(7);
        pay_and_open();
        cyc(0, 0, 0, 0, 0, 0);
        check_eq("s6_gate_up", int'(gate_open), 1);
        check_eq("s6_occ7", int'(occupancy), 7);
        cyc(1, 1, 1, 1, 1, 1);
        check_eq("s6_gate_rst", int'(gate_open), 0);
        check_eq("s6_occ_rst", int'(occupancy), 0);
        check_eq("s6_empty_rst", int'(empty), 1);
        $display("scenario reset_mid_open done occ=%0d", occupancy);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) s_lvl = ~s_lvl;
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) == 0),
                s_lvl,
                ($urandom_range(0, 6) == 0),
                ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 6) == 0));
        end
        $display("scenario random_traffic done cycles=3000 occ=%0d", occupancy);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
